cnn_mem_port_arbiter: RTL and testbench
=======================================

Name: cnn_mem_port_arbiter

Overview:
- Shares the single layer-memory port of the CONV engine between up to N_REQ internal requesters. The port signals are crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr and cdata_rd; the requesters are the L0 conv writer, the L1 max-pool reader/writer and the L2 flatten reader/writer.
- Arbitration is round-robin; one command is issued per cycle.
- Commands are registered toward memory, and read data is routed back to the issuing requester with a fixed latency.
- Sits between the CONV datapath engines and the top-level memory pins.

Parameters:
- N_REQ, 3, number of requesters (2..4).
- ADDR_W, 12, memory address width.
- DATA_W, 20, memory data width (signed fixed-point word).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- arb_en  in  1  when low, no grants are issued; commands already in flight complete.
- req  in  N_REQ  per-requester command valid.
- req_we  in  N_REQ  1 = write, 0 = read.
- req_sel  in  3*N_REQ  target memory select (1..5), packed as requester i at [3i+2:3i].
- req_addr  in  ADDR_W*N_REQ  packed addresses.
- req_wdata  in  DATA_W*N_REQ  packed write data.
- gnt  out  N_REQ  combinational one-hot ready; a transfer occurs at a posedge with req[i]&gnt[i].
- rvalid  out  N_REQ  one-hot; marks the cycle in which rdata is valid for requester i.
- rdata  out  DATA_W  read data, shared by all requesters.
- crd  out  1  memory read strobe.
- cwr  out  1  memory write strobe.
- csel  out  3  memory select.
- caddr_rd  out  ADDR_W  read address.
- caddr_wr  out  ADDR_W  write address.
- cdata_wr  out  DATA_W  write data.
- cdata_rd  in  DATA_W  memory read data; the memory drives it mid-cycle, and it is valid at the posedge ending the crd cycle.
- sel_err  out  1  sticky flag: a granted command carried an illegal select.

Behaviour:
- Reset (async, asserted): crd=0, cwr=0, csel=0, caddr_rd=0, caddr_wr=0, cdata_wr=0, rvalid=0, sel_err=0, rr_ptr=0.
- While reset is high, gnt=0 regardless of req. This also applies to reset arriving mid-operation: any in-flight command is discarded and its rvalid never asserts.
- Grant (combinational):
  - If arb_en=1 and req is nonzero, gnt = one-hot of the first set req[i] scanning from rr_ptr upward, wrapping modulo N_REQ.
  - Otherwise gnt=0.
- Pointer update: on each transfer, rr_ptr <= winner+1 modulo N_REQ, and wraps from N_REQ-1 to 0. With no transfer, rr_ptr holds.
- Issue (registered, one cycle after the transfer edge):
  - Winner read: crd=1, cwr=0, caddr_rd=addr, csel=sel.
  - Winner write: cwr=1, crd=0, caddr_wr=addr, cdata_wr=wdata, csel=sel.
  - Exactly one strobe per cycle; crd and cwr are never both high.
  - With no transfer, both strobes =0 next cycle; csel, caddr_rd, caddr_wr and cdata_wr hold their last values.
- Read return:
  - rvalid[i]=1 in the same cycle crd is high for requester i's command.
  - rdata = cdata_rd passed through combinationally; the requester captures it at the posedge ending that cycle.
  - Read latency is 1 cycle from the transfer edge to the rvalid cycle. Back-to-back reads give 1 word per cycle.
- Throughput: one transfer per cycle. A requester holding req high wins again only after all other active requesters have been served once.
- Illegal select (req_sel of 0, 6 or 7):
  - The command is granted and the pointer advances, but no strobe is issued.
  - sel_err is set and stays set until reset.
  - For a read, rvalid[i] still asserts in the issue cycle with rdata=0.
- arb_en falling: gnt drops immediately (combinational). The command registered at the previous edge still issues.
- Requester rules:
  - Payload must be stable while req=1 and gnt=0.
  - Payload may change at the transfer edge.
  - Requesters must not depend on gnt timing beyond the valid/ready rule.

Decomposition:
- Package cnn_mem_pkg holds:
  - CSEL_NONE=0, CSEL_L0_K0=1, CSEL_L0_K1=2, CSEL_L1_K0=3, CSEL_L1_K1=4, CSEL_L2=5.
  - ADDR_W and DATA_W defaults.
  - mem_cmd_t struct (we, sel, addr, wdata).
- One sub-module, rr_pick: parameterized combinational round-robin priority picker with inputs req and rr_ptr, output one-hot winner. It is reused by other shared-resource blocks.

Test Plan:
- Single write: req[0]=1, we=1, sel=1, addr=0x3F, wdata=0x00A5C.
  - gnt[0]=1 in the same cycle.
  - Next cycle: cwr=1, csel=1, caddr_wr=0x03F, cdata_wr=0x00A5C, crd=0.
- Read return: req[1]=1, we=0, sel=3, addr=0x010, memory L1_K0[0x010]=0x12345.
  - Next cycle: crd=1, caddr_rd=0x010, rvalid=3'b010.
  - rdata=0x12345 sampled at that cycle's end.
- Round-robin fairness: all three req held for 6 cycles from reset.
  - gnt order 0,1,2,0,1,2; csel follows each winner's sel one cycle later.
- Illegal select: req[2]=1, we=0, sel=7.
  - gnt[2]=1; next cycle crd=0, cwr=0, rvalid=3'b100, rdata=0.
  - sel_err=1 and stays 1 until reset.
- arb_en gating: arb_en=0 with req=3'b111 → gnt=0 and no strobes. Raise arb_en → gnt[rr_ptr] within the same cycle.
- Reset mid-stream: assert reset during a pending read cycle.
  - crd, cwr, rvalid and gnt =0 immediately.
  - After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/cnn_mem_pkg.sv
// Shared types and constants for the CONV layer-memory port.
// Memory selects, default bus widths and the command record used by port arbiters.
package cnn_mem_pkg;

    localparam int CNN_ADDR_W = 12;
    localparam int CNN_DATA_W = 20;
    localparam int SEL_W      = 3;

    typedef enum logic [SEL_W-1:0] {
        CSEL_NONE  = 3'd0,
        CSEL_L0_K0 = 3'd1,
        CSEL_L0_K1 = 3'd2,
        CSEL_L1_K0 = 3'd3,
        CSEL_L1_K1 = 3'd4,
        CSEL_L2    = 3'd5
    } csel_e;

    typedef struct packed {
        logic                  we;
        logic [SEL_W-1:0]      sel;
        logic [CNN_ADDR_W-1:0] addr;
        logic [CNN_DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Selects 0, 6 and 7 address no memory.
    function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
        return (sel >= CSEL_L0_K0) && (sel <= CSEL_L2);
    endfunction

endpackage

// File: rtl/cnn_mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot of the first set request at or above
// ptr_i, wrapping modulo N. Zero when no request is set.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn_mem_port_arbiter.sv
// Round-robin arbiter sharing the CONV layer-memory port between internal requesters.
// Commands are registered toward memory; read data returns combinationally in the issue cycle.
module cnn_mem_port_arbiter
    import cnn_mem_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = CNN_ADDR_W,
    parameter int DATA_W = CNN_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      arb_en,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [SEL_W*N_REQ-1:0]    req_sel,
    input  logic [ADDR_W*N_REQ-1:0]   req_addr,
    input  logic [DATA_W*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      crd,
    output logic                      cwr,
    output logic [SEL_W-1:0]          csel,
    output logic [ADDR_W-1:0]         caddr_rd,
    output logic [ADDR_W-1:0]         caddr_wr,
    output logic [DATA_W-1:0]         cdata_wr,
    input  logic [DATA_W-1:0]         cdata_rd,
    output logic                      sel_err
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  pick;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     win_idx;
    mem_cmd_t          win_cmd;
    logic              xfer;

    logic              crd_q, crd_d;
    logic              cwr_q, cwr_d;
    logic [SEL_W-1:0]  csel_q, csel_d;
    logic [ADDR_W-1:0] caddr_rd_q, caddr_rd_d;
    logic [ADDR_W-1:0] caddr_wr_q, caddr_wr_d;
    logic [DATA_W-1:0] cdata_wr_q, cdata_wr_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;
    logic              rd_zero_q, rd_zero_d;
    logic              sel_err_q, sel_err_d;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick)
    );

    assign gnt  = (!reset && arb_en) ? pick : '0;
    assign xfer = |(req & gnt);

    always_comb begin
        win_idx = '0;
        win_cmd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                win_idx       = PW'(i);
                win_cmd.we    = req_we[i];
                win_cmd.sel   = req_sel[SEL_W*i +: SEL_W];
                win_cmd.addr  = req_addr[ADDR_W*i +: ADDR_W];
                win_cmd.wdata = req_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        crd_d      = 1'b0;
        cwr_d      = 1'b0;
        csel_d     = csel_q;
        caddr_rd_d = caddr_rd_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        rvalid_d   = '0;
        rd_zero_d  = 1'b0;
        sel_err_d  = sel_err_q;
        if (xfer) begin
            rr_ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
            if (!win_cmd.we) begin
                rvalid_d = gnt;
            end
            if (sel_legal(win_cmd.sel)) begin
                csel_d = win_cmd.sel;
                if (win_cmd.we) begin
                    cwr_d      = 1'b1;
                    caddr_wr_d = win_cmd.addr;
                    cdata_wr_d = win_cmd.wdata;
                end else begin
                    crd_d      = 1'b1;
                    caddr_rd_d = win_cmd.addr;
                end
            end else begin
                // Illegal select: consume the command, strobe nothing, reads return zero.
                sel_err_d = 1'b1;
                rd_zero_d = !win_cmd.we;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            csel_q     <= '0;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            rvalid_q   <= '0;
            rd_zero_q  <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            csel_q     <= csel_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            rvalid_q   <= rvalid_d;
            rd_zero_q  <= rd_zero_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign crd      = crd_q;
    assign cwr      = cwr_q;
    assign csel     = csel_q;
    assign caddr_rd = caddr_rd_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;
    assign rvalid   = rvalid_q;
    assign sel_err  = sel_err_q;
    assign rdata    = rd_zero_q ? '0 : cdata_rd;

endmodule

// File: tb/tb_cnn_mem_port_arbiter.sv
// Bench for cnn_mem_port_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_cnn_mem_port_arbiter;

    logic        clk, reset, arb_en;
    logic [2:0]  req, req_we, gnt, rvalid;
    logic [8:0]  req_sel;
    logic [35:0] req_addr;
    logic [59:0] req_wdata;
    logic [19:0] rdata, cdata_wr, cdata_rd;
    logic        crd, cwr, sel_err;
    logic [2:0]  csel;
    logic [11:0] caddr_rd, caddr_wr;

    cnn_mem_port_arbiter #(.N_REQ(3), .ADDR_W(12), .DATA_W(20)) dut (
        .clk(clk), .reset(reset), .arb_en(arb_en),
        .req(req), .req_we(req_we), .req_sel(req_sel),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .crd(crd), .cwr(cwr), .csel(csel),
        .caddr_rd(caddr_rd), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .cdata_rd(cdata_rd), .sel_err(sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory: always presents the word at the current read address.
    logic [19:0] mem [8][4096];
    logic [19:0] ref_mem [8][4096];
    assign cdata_rd = mem[csel][caddr_rd];
    always @(posedge clk) if (cwr) mem[csel][caddr_wr] <= cdata_wr;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic [2:0]  rq, we;
        logic [8:0]  sel;
        logic [11:0] abase;
        logic [19:0] wbase;
        logic [2:0]  e_gnt;
        logic        e_crd, e_cwr;
        logic [2:0]  e_csel, e_rv;
        logic [11:0] e_ard, e_awr;
        logic [19:0] e_wd, e_rdata;
        logic        e_err, chk_rd, chk_wr;
    } vec_t;

    vec_t tbl[10];

    task automatic drive(input logic en, input logic [2:0] rq, input logic [2:0] we,
                         input logic [8:0] sel, input logic [11:0] ab, input logic [19:0] wb);
        arb_en    = en;
        req       = rq;
        req_we    = we;
        req_sel   = sel;
        req_addr  = {ab + 12'd2, ab + 12'd1, ab};
        req_wdata = {wb + 20'd2, wb + 20'd1, wb};
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    // Reference model state
    int          m_ptr;
    logic [2:0]  p_req, p_we;
    logic [2:0]  p_sel [3];
    logic [11:0] p_addr [3];
    logic [19:0] p_wd [3];
    logic        e_crd, e_cwr, e_err, csel_k, ard_k, awr_k;
    logic [2:0]  e_csel, e_rv;
    logic [11:0] e_ard, e_awr;
    logic [19:0] e_wd, e_rdata;

    function automatic logic [2:0] model_gnt(input logic en, input logic [2:0] rq, input int ptr);
        logic [2:0] g;
        g = 3'b000;
        if (en) begin
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (ptr + k) % 3;
                if (g == 3'b000 && rq[i]) g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic new_payload(input int i);
        p_we[i]   = 1'($urandom_range(0, 1));
        p_sel[i]  = 3'($urandom_range(0, 7));
        p_addr[i] = 12'h800 + 12'($urandom_range(0, 15));
        p_wd[i]   = 20'($urandom);
    endtask

    initial begin
        logic [2:0] g;
        logic       en;
        int         w;
        for (int s = 0; s < 8; s++)
            for (int a = 0; a < 4096; a++) begin
                mem[s][a]     = 20'(s * 65536 + a);
                ref_mem[s][a] = 20'(s * 65536 + a);
            end
        mem[3][16] = 20'h12345;

        //       en  req     we      sel           abase   wbase      gnt    crd  cwr  csel  rv      ard     awr     wd         rdata      err  crd? cwr?
        tbl[0] = '{1'b1, 3'b001, 3'b001, 9'b000_000_001, 12'h03F, 20'h00A5C, 3'b001, 1'b0, 1'b1, 3'd1, 3'b000, 12'h000, 12'h03F, 20'h00A5C, 20'h00000, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 3'b010, 3'b000, 9'b000_011_000, 12'h00F, 20'h00000, 3'b010, 1'b1, 1'b0, 3'd3, 3'b010, 12'h010, 12'h03F, 20'h00A5C, 20'h12345, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 3'b111, 3'b111, 9'b101_100_011, 12'h200, 20'h11110, 3'b100, 1'b0, 1'b1, 3'd5, 3'b000, 12'h010, 12'h202, 20'h11112, 20'h00000, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 3'b110, 3'b000, 9'b100_010_000, 12'h300, 20'h00000, 3'b010, 1'b1, 1'b0, 3'd2, 3'b010, 12'h301, 12'h202, 20'h11112, 20'h20301, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 3'b100, 3'b000, 9'b111_000_000, 12'h400, 20'h00000, 3'b100, 1'b0, 1'b0, 3'd0, 3'b100, 12'h000, 12'h000, 20'h00000, 20'h00000, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 3'b111, 3'b000, 9'b001_001_001, 12'h500, 20'h00000, 3'b000, 1'b0, 1'b0, 3'd0, 3'b000, 12'h000, 12'h000, 20'h00000, 20'h00000, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 3'b111, 3'b000, 9'b001_001_001, 12'h500, 20'h00000, 3'b001, 1'b1, 1'b0, 3'd1, 3'b001, 12'h500, 12'h000, 20'h00000, 20'h10500, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 3'b000, 3'b000, 9'b000_000_000, 12'h000, 20'h00000, 3'b000, 1'b0, 1'b0, 3'd1, 3'b000, 12'h500, 12'h000, 20'h00000, 20'h00000, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 3'b010, 3'b010, 9'b000_100_000, 12'h600, 20'h22220, 3'b010, 1'b0, 1'b1, 3'd4, 3'b000, 12'h500, 12'h601, 20'h22221, 20'h00000, 1'b1, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 3'b111, 3'b000, 9'b001_001_001, 12'h700, 20'h00000, 3'b000, 1'b0, 1'b0, 3'd4, 3'b000, 12'h500, 12'h601, 20'h22221, 20'h00000, 1'b1, 1'b1, 1'b1};

        // Reset state, with requests pending during reset
        reset = 1'b1;
        drive(1'b1, 3'b111, 3'b000, 9'b001_001_001, 12'h000, 20'h0);
        #3 chk("gnt_in_reset", 32'(gnt), 32'(3'b000));
        @(posedge clk); #1;
        chk("rst_crd", 32'(crd), 0);
        chk("rst_cwr", 32'(cwr), 0);
        chk("rst_csel", 32'(csel), 0);
        chk("rst_caddr_rd", 32'(caddr_rd), 0);
        chk("rst_caddr_wr", 32'(caddr_wr), 0);
        chk("rst_cdata_wr", 32'(cdata_wr), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_sel_err", 32'(sel_err), 0);
        #1 reset = 1'b0;

        // Directed table
        for (int v = 0; v < 10; v++) begin
            drive(tbl[v].en, tbl[v].rq, tbl[v].we, tbl[v].sel, tbl[v].abase, tbl[v].wbase);
            #1 chk($sformatf("v%0d_gnt", v), 32'(gnt), 32'(tbl[v].e_gnt));
            @(posedge clk); #1;
            chk($sformatf("v%0d_crd", v), 32'(crd), 32'(tbl[v].e_crd));
            chk($sformatf("v%0d_cwr", v), 32'(cwr), 32'(tbl[v].e_cwr));
            chk($sformatf("v%0d_rvalid", v), 32'(rvalid), 32'(tbl[v].e_rv));
            chk($sformatf("v%0d_sel_err", v), 32'(sel_err), 32'(tbl[v].e_err));
            if (tbl[v].chk_rd) begin
                chk($sformatf("v%0d_csel", v), 32'(csel), 32'(tbl[v].e_csel));
                chk($sformatf("v%0d_caddr_rd", v), 32'(caddr_rd), 32'(tbl[v].e_ard));
            end
            if (tbl[v].chk_wr) begin
                chk($sformatf("v%0d_caddr_wr", v), 32'(caddr_wr), 32'(tbl[v].e_awr));
                chk($sformatf("v%0d_cdata_wr", v), 32'(cdata_wr), 32'(tbl[v].e_wd));
            end
            if (tbl[v].e_rv != 3'b000)
                chk($sformatf("v%0d_rdata", v), 32'(rdata), 32'(tbl[v].e_rdata));
        end

        // Fairness from reset: all three reading, selects 1,2,3
        pulse_reset();
        chk("fair_sel_err_cleared", 32'(sel_err), 0);
        drive(1'b1, 3'b111, 3'b000, 9'b011_010_001, 12'h700, 20'h0);
        for (int k = 0; k < 6; k++) begin
            #1 chk($sformatf("fair%0d_gnt", k), 32'(gnt), 32'(3'b001 << (k % 3)));
            @(posedge clk); #1;
            chk($sformatf("fair%0d_csel", k), 32'(csel), 32'((k % 3) + 1));
            chk($sformatf("fair%0d_rvalid", k), 32'(rvalid), 32'(3'b001 << (k % 3)));
            chk($sformatf("fair%0d_rdata", k), 32'(rdata), 32'(((k % 3) + 1) * 65536 + 32'h700 + (k % 3)));
        end

        // Reset arriving while a read is in its issue cycle
        pulse_reset();
        drive(1'b1, 3'b010, 3'b000, 9'b000_011_000, 12'h00F, 20'h0);
        @(posedge clk); #1;
        chk("mid_crd_before", 32'(crd), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_crd", 32'(crd), 0);
        chk("mid_cwr", 32'(cwr), 0);
        chk("mid_rvalid", 32'(rvalid), 0);
        chk("mid_gnt", 32'(gnt), 0);
        drive(1'b1, 3'b111, 3'b000, 9'b001_001_001, 12'h000, 20'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("mid_first_gnt", 32'(gnt), 32'(3'b001));

        // Randomized run against the reference model
        pulse_reset();
        m_ptr = 0;
        e_crd = 0; e_cwr = 0; e_err = 0; e_rv = 0; e_rdata = 0;
        e_csel = 0; e_ard = 0; e_awr = 0; e_wd = 0;
        csel_k = 1; ard_k = 1; awr_k = 1;
        for (int i = 0; i < 3; i++) begin
            new_payload(i);
            p_req[i] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(0, 9) < 8);
            arb_en = en;
            req    = p_req;
            req_we = p_we;
            for (int i = 0; i < 3; i++) begin
                req_sel[3*i +: 3]     = p_sel[i];
                req_addr[12*i +: 12]  = p_addr[i];
                req_wdata[20*i +: 20] = p_wd[i];
            end
            g = model_gnt(en, p_req, m_ptr);
            #1 chk($sformatf("rnd%0d_gnt", c), 32'(gnt), 32'(g));
            @(posedge clk);
            e_crd = 0; e_cwr = 0; e_rv = 0;
            if (g != 3'b000) begin
                w = (g[0]) ? 0 : (g[1]) ? 1 : 2;
                m_ptr = (w + 1) % 3;
                if (!p_we[w]) e_rv = 3'(1 << w);
                if (p_sel[w] >= 3'd1 && p_sel[w] <= 3'd5) begin
                    e_csel = p_sel[w]; csel_k = 1;
                    if (p_we[w]) begin
                        e_cwr = 1; e_awr = p_addr[w]; e_wd = p_wd[w]; awr_k = 1;
                        ref_mem[p_sel[w]][p_addr[w]] = p_wd[w];
                    end else begin
                        e_crd = 1; e_ard = p_addr[w]; ard_k = 1;
                        e_rdata = ref_mem[p_sel[w]][p_addr[w]];
                    end
                end else begin
                    e_err = 1; e_rdata = 0;
                    csel_k = 0; ard_k = 0; awr_k = 0;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (g[i]) begin
                    new_payload(i);
                    p_req[i] = ($urandom_range(0, 9) < 7);
                end else if (!p_req[i] && $urandom_range(0, 1) == 1) begin
                    new_payload(i);
                    p_req[i] = 1'b1;
                end
            end
            #1;
            chk($sformatf("rnd%0d_crd", c), 32'(crd), 32'(e_crd));
            chk($sformatf("rnd%0d_cwr", c), 32'(cwr), 32'(e_cwr));
            chk($sformatf("rnd%0d_rvalid", c), 32'(rvalid), 32'(e_rv));
            chk($sformatf("rnd%0d_sel_err", c), 32'(sel_err), 32'(e_err));
            if (csel_k) chk($sformatf("rnd%0d_csel", c), 32'(csel), 32'(e_csel));
            if (ard_k)  chk($sformatf("rnd%0d_caddr_rd", c), 32'(caddr_rd), 32'(e_ard));
            if (awr_k) begin
                chk($sformatf("rnd%0d_caddr_wr", c), 32'(caddr_wr), 32'(e_awr));
                chk($sformatf("rnd%0d_cdata_wr", c), 32'(cdata_wr), 32'(e_wd));
            end
            if (e_rv != 3'b000) chk($sformatf("rnd%0d_rdata", c), 32'(rdata), 32'(e_rdata));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
